value_display_scan: RTL and testbench



---
 rtl/disp_pkg.sv | 19 +
 rtl/seg7_encode.sv | 23 ++
 rtl/value_display_scan.sv | 139 +++++++++++++
 tb/tb_value_display_scan.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the value display path: conversion FSM states and
// the common-anode 7-segment code table (active-low, {dp,g,f,e,d,c,b,a}).
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Digit glyphs 0..9, decimal point off
  localparam logic [7:0] SEG_CODE [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD-nibble to active-low 7-segment encoder with blanking and
// an independent decimal point (the dp still lights on a blanked digit).
module seg7_encode
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  // Glyph lookup, then overlay the decimal point
  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (nibble <= 4'd9)) begin
      seg = SEG_CODE[nibble];
    end
    if (dp) begin
      seg[7] = 1'b0;
    end
  end

endmodule

// File: rtl/value_display_scan.sv
// Converts an 8-bit binary value to three BCD digits with a bit-serial
// double-dabble engine and time-multiplexes them onto a 4-digit common-anode
// display. The display only ever reads the committed result, so a conversion
// in flight never disturbs what is shown.
module value_display_scan
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 0,
  parameter bit LZB      = 1'b1
) (
  input  logic       clk50hz,
  input  logic       nrst,
  input  logic [7:0] value,
  input  logic       load,
  input  logic [3:0] dp_en,
  output logic       busy,
  output logic [7:0] seg,
  output logic [3:0] dig
);

  localparam int TW = (SCAN_DIV < 1) ? 1 : $clog2(SCAN_DIV + 1);

  conv_state_t state, state_nxt;

  logic [7:0]    shift_reg;
  logic [11:0]   bcd_acc;
  logic [11:0]   bcd_adj;
  logic [2:0]    bit_cnt;
  logic [11:0]   disp_bcd;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [1:0]    d;
  logic [3:0]    enc_nib;
  logic          enc_blank;
  logic          enc_dp;
  logic [7:0]    enc_seg;

  // Conversion FSM state register
  always_ff @(posedge clk50hz or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; busy covers every non-idle cycle
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (load) state_nxt = CONV;
      CONV:    if (bit_cnt == 3'd7) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble that would overflow when doubled
  always_comb begin
    bcd_adj = bcd_acc;
    for (int i = 0; i < 3; i++) begin
      if (bcd_acc[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_acc[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Conversion datapath: capture on load, shift one bit per CONV cycle
  always_ff @(posedge clk50hz) begin
    if ((state == IDLE) && load) begin
      shift_reg <= value;
      bcd_acc   <= '0;
    end else if (state == CONV) begin
      {bcd_acc, shift_reg} <= {bcd_adj, shift_reg} << 1;
    end
  end

  // Bit counter and committed display value
  always_ff @(posedge clk50hz or negedge nrst) begin
    if (!nrst) begin
      bit_cnt  <= '0;
      disp_bcd <= '0;
    end else begin
      if ((state == IDLE) && load) bit_cnt <= '0;
      else if (state == CONV)      bit_cnt <= bit_cnt + 3'd1;
      if (state == COMMIT)         disp_bcd <= bcd_acc;
    end
  end

  assign tick = (tick_cnt == TW'(SCAN_DIV));

  // Select content, blanking and decimal point for the digit being scanned
  always_comb begin
    enc_nib   = 4'd0;
    enc_blank = 1'b1;
    enc_dp    = dp_en[d];
    case (d)
      2'd0: begin
        enc_nib   = disp_bcd[3:0];
        enc_blank = 1'b0;
      end
      2'd1: begin
        enc_nib   = disp_bcd[7:4];
        enc_blank = LZB && (disp_bcd[11:8] == 4'd0) && (disp_bcd[7:4] == 4'd0);
      end
      2'd2: begin
        enc_nib   = disp_bcd[11:8];
        enc_blank = LZB && (disp_bcd[11:8] == 4'd0);
      end
      default: begin
        enc_nib   = 4'd0;
        enc_blank = 1'b1;
      end
    endcase
  end

  seg7_encode u_enc (
    .nibble (enc_nib),
    .blank  (enc_blank),
    .dp     (enc_dp),
    .seg    (enc_seg)
  );

  // Scan divider, digit index and registered display outputs
  always_ff @(posedge clk50hz or negedge nrst) begin
    if (!nrst) begin
      tick_cnt <= '0;
      d        <= 2'd0;
      dig      <= 4'b1111;
      seg      <= SEG_BLANK;
    end else if (tick) begin
      tick_cnt <= '0;
      d        <= d + 2'd1;
      dig      <= ~(4'b0001 << d);
      seg      <= enc_seg;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_value_display_scan.sv
// Bench for value_display_scan: three instances share stimulus
// (LZB on, LZB off, and a slowed scan) and are compared against a decimal
// digit model of the display.
module tb_value_display_scan;

  localparam logic [7:0] TBL [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  logic       clk50hz = 1'b0;
  logic       nrst    = 1'b0;
  logic [7:0] value   = 8'd0;
  logic       load    = 1'b0;
  logic [3:0] dp_en   = 4'd0;

  logic       busy_a, busy_b, busy_s;
  logic [7:0] seg_a, seg_b, seg_s;
  logic [3:0] dig_a, dig_b, dig_s;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] cap_a [0:3];
  logic [7:0] cap_b [0:3];

  always #5 clk50hz = ~clk50hz;

  value_display_scan #(.SCAN_DIV(0), .LZB(1'b1)) dut (
    .clk50hz(clk50hz), .nrst(nrst), .value(value), .load(load), .dp_en(dp_en),
    .busy(busy_a), .seg(seg_a), .dig(dig_a)
  );

  value_display_scan #(.SCAN_DIV(0), .LZB(1'b0)) dut_nl (
    .clk50hz(clk50hz), .nrst(nrst), .value(value), .load(load), .dp_en(dp_en),
    .busy(busy_b), .seg(seg_b), .dig(dig_b)
  );

  value_display_scan #(.SCAN_DIV(2), .LZB(1'b1)) dut_s2 (
    .clk50hz(clk50hz), .nrst(nrst), .value(value), .load(load), .dp_en(dp_en),
    .busy(busy_s), .seg(seg_s), .dig(dig_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected segment pattern from plain decimal arithmetic
  function automatic logic [7:0] exp_seg(int v, int d, bit lzb, logic [3:0] dp);
    int h, t, o, digit;
    bit blank;
    logic [7:0] s;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    case (d)
      0: begin digit = o; blank = 1'b0; end
      1: begin digit = t; blank = lzb && (h == 0) && (t == 0); end
      2: begin digit = h; blank = lzb && (h == 0); end
      default: begin digit = 0; blank = 1'b1; end
    endcase
    s = blank ? 8'hFF : TBL[digit];
    if (dp[d]) s[7] = 1'b0;
    return s;
  endfunction

  function automatic int dig_idx(logic [3:0] dg);
    case (dg)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return 4;
    endcase
  endfunction

  // Record one full scan of both fast instances, starting at the current sample
  task automatic capture();
    int ia, ib;
    for (int k = 0; k < 4; k++) begin
      cap_a[k] = 8'h00;
      cap_b[k] = 8'h00;
    end
    for (int k = 0; k < 4; k++) begin
      ia = dig_idx(dig_a);
      ib = dig_idx(dig_b);
      if (ia == 4) chk("dig_onehot_a", {28'd0, dig_a}, 32'h0000000E);
      else cap_a[ia] = seg_a;
      if (ib == 4) chk("dig_onehot_b", {28'd0, dig_b}, 32'h0000000E);
      else cap_b[ib] = seg_b;
      @(negedge clk50hz);
    end
  endtask

  task automatic check_display(input int v, input logic [3:0] dp, input bit with_nl);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("v%0d_lzb1_d%0d", v, d), {24'd0, cap_a[d]}, {24'd0, exp_seg(v, d, 1'b1, dp)});
      if (with_nl)
        chk($sformatf("v%0d_lzb0_d%0d", v, d), {24'd0, cap_b[d]}, {24'd0, exp_seg(v, d, 1'b0, dp)});
    end
  endtask

  // Pulse load, measure busy length, then verify the resulting display
  task automatic convert_and_check(input int v);
    int bcnt;
    value = 8'(v);
    load  = 1'b1;
    @(negedge clk50hz);
    load  = 1'b0;
    bcnt  = 0;
    while (busy_a && bcnt < 40) begin
      bcnt++;
      @(negedge clk50hz);
    end
    chk($sformatf("busy_len_v%0d", v), bcnt, 9);
    @(negedge clk50hz);
    capture();
    check_display(v, dp_en, 1'b1);
  endtask

  initial begin
    int hi, w, prev, found;

    // Reset state
    repeat (2) @(negedge clk50hz);
    chk("rst_busy", {31'd0, busy_a}, 0);
    chk("rst_dig", {28'd0, dig_a}, 32'hF);
    chk("rst_seg", {24'd0, seg_a}, 32'hFF);
    chk("rst_dig_s2", {28'd0, dig_s}, 32'hF);
    nrst = 1'b1;
    @(negedge clk50hz);
    chk("first_dig", {28'd0, dig_a}, 32'hE);
    chk("first_seg", {24'd0, seg_a}, 32'hC0);
    @(negedge clk50hz);
    chk("second_dig", {28'd0, dig_a}, 32'hD);
    chk("second_seg", {24'd0, seg_a}, 32'hFF);

    // Directed values, then randomized values with random decimal points
    dp_en = 4'd0;
    convert_and_check(173);
    convert_and_check(5);
    convert_and_check(0);
    convert_and_check(255);
    for (int r = 0; r < 8; r++) begin
      dp_en = 4'($urandom_range(0, 15));
      convert_and_check(int'($urandom_range(0, 255)));
    end

    // Loads while busy are ignored; the first load after return to idle is taken
    dp_en = 4'd0;
    value = 8'd42;
    load  = 1'b1;
    @(negedge clk50hz);
    load  = 1'b0;
    value = 8'd99;
    hi    = 0;
    for (int i = 0; i < 9; i++) begin
      if (busy_a) hi++;
      load = (i == 2) || (i == 8);
      @(negedge clk50hz);
    end
    chk("busy_single_pulse", hi, 9);
    chk("busy_low_n9", {31'd0, busy_a}, 0);
    @(negedge clk50hz);
    load = 1'b0;
    chk("reload_accepted", {31'd0, busy_a}, 1);
    @(negedge clk50hz);
    capture();
    check_display(42, 4'd0, 1'b0);
    w = 0;
    while (busy_a && w < 40) begin
      w++;
      @(negedge clk50hz);
    end
    chk("reload_done", {31'd0, busy_a}, 0);
    @(negedge clk50hz);
    capture();
    check_display(99, 4'd0, 1'b0);

    // Reset in the middle of a conversion
    value = 8'd200;
    load  = 1'b1;
    @(negedge clk50hz);
    load  = 1'b0;
    repeat (3) @(negedge clk50hz);
    chk("midconv_busy_before", {31'd0, busy_a}, 1);
    nrst = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy_a}, 0);
    chk("midrst_dig", {28'd0, dig_a}, 32'hF);
    chk("midrst_seg", {24'd0, seg_a}, 32'hFF);
    @(negedge clk50hz);
    nrst = 1'b1;
    @(negedge clk50hz);
    capture();
    check_display(0, 4'd0, 1'b1);

    // Slow scan cadence with the leftmost decimal point lit
    dp_en = 4'b1000;
    prev  = int'(dig_s);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk50hz);
      if (dig_s == 4'b1110 && prev == 4'b0111) found = 1;
      else prev = int'(dig_s);
    end
    chk("s2_sync", found, 1);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("s2_dig_k%0d", k), {28'd0, dig_s}, {28'd0, ~(4'b0001 << (k / 3))});
      chk($sformatf("s2_seg_k%0d", k), {24'd0, seg_s}, {24'd0, exp_seg(0, k / 3, 1'b1, 4'b1000)});
      @(negedge clk50hz);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
